// File: rtl/ice40_audio_buf_pkg.sv
// Shared constants for the audio feature-buffer arbiter: state encodings,
// default geometry and write-queue entry layout.
package ice40_audio_buf_pkg;

  localparam int DEF_ADDR_W   = 14;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_WQ_DEPTH = 8;

  // Queue entry is {blk_end, addr, data}, blk_end in the MSB.
  localparam int WQ_BLK_W = 1;

  localparam logic [1:0] S_WR    = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_LOCK  = 2'd2;

  function automatic int wq_entry_w(input int aw, input int dw);
    return WQ_BLK_W + aw + dw;
  endfunction

endpackage

// File: rtl/ice40_audio_wq.sv
// Synchronous FIFO used as the front-end write queue; head entry is
// presented combinationally so it can be written to memory on the pop cycle.
module ice40_audio_wq #(
  parameter int W     = 31,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     din_i,
  output logic [W-1:0]     dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ice40_audio_buf_arb.sv
// Arbitrates a single-port SPRAM between a queued front-end writer and an
// NN engine that takes exclusive read windows after the queue is drained.
module ice40_audio_buf_arb
  import ice40_audio_buf_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WQ_DEPTH = DEF_WQ_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_blk_end,
  output logic              o_wr_full,
  input  logic              i_rd_req,
  input  logic              i_rd_hold,
  output logic              o_rd_rdy,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_vld,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [7:0]        o_blk_idx,
  output logic [7:0]        o_drop_cnt
);

  localparam int ENT_W = wq_entry_w(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(WQ_DEPTH) + 1;

  logic [1:0]       state_q, state_d;
  logic [7:0]       blk_idx_q, blk_idx_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             rd_vld_q, rd_vld_d;

  logic [ENT_W-1:0] wq_din, wq_dout;
  logic             wq_full, wq_empty, wq_pop;
  logic [CNT_W-1:0] wq_count;
  logic             ent_blk_end;
  logic [ADDR_W-1:0] ent_addr;
  logic [DATA_W-1:0] ent_data;
  logic             lock;

  assign wq_din      = {i_wr_blk_end, i_wr_addr, i_wr_data};
  assign ent_blk_end = wq_dout[ENT_W-1];
  assign ent_addr    = wq_dout[DATA_W +: ADDR_W];
  assign ent_data    = wq_dout[DATA_W-1:0];

  assign lock   = (state_q == S_LOCK);
  assign wq_pop = !wq_empty && !lock;

  ice40_audio_wq #(
    .W     (ENT_W),
    .DEPTH (WQ_DEPTH)
  ) u_wq (
    .clk     (clk),
    .reset   (reset),
    .push_i  (i_wr_req),
    .pop_i   (wq_pop),
    .din_i   (wq_din),
    .dout_o  (wq_dout),
    .full_o  (wq_full),
    .empty_o (wq_empty),
    .count_o (wq_count)
  );

  // Grant only on a cycle the queue is empty, so late writes extend the drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WR:    if (i_rd_req) state_d = S_DRAIN;
      S_DRAIN: if (wq_count == '0 && !wq_pop) state_d = S_LOCK;
      S_LOCK:  if (!i_rd_req && !i_rd_hold) state_d = S_WR;
      default: state_d = S_WR;
    endcase
  end

  always_comb begin
    blk_idx_d  = blk_idx_q;
    drop_cnt_d = drop_cnt_q;
    if (wq_pop && ent_blk_end) blk_idx_d = blk_idx_q + 8'd1;
    if (i_wr_req && wq_full && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    rd_vld_d = i_rd_en && lock;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_WR;
      blk_idx_q  <= '0;
      drop_cnt_q <= '0;
      rd_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_idx_q  <= blk_idx_d;
      drop_cnt_q <= drop_cnt_d;
      rd_vld_q   <= rd_vld_d;
    end
  end

  assign o_wr_full   = wq_full;
  assign o_rd_rdy    = lock;
  assign o_rd_vld    = rd_vld_q;
  assign o_rd_data   = i_mem_rdata;
  assign o_mem_we    = wq_pop;
  assign o_mem_addr  = lock ? i_rd_addr : ent_addr;
  assign o_mem_wdata = ent_data;
  assign o_blk_idx   = blk_idx_q;
  assign o_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_ice40_audio_buf_arb.sv
// Directed bench for the audio buffer arbiter; a behavioural SPRAM model
// with 1-cycle read latency sits on the memory port.
module tb_ice40_audio_buf_arb;

  localparam int AW = 14;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_wr_req, i_wr_blk_end;
  logic [AW-1:0] i_wr_addr;
  logic [DW-1:0] i_wr_data;
  logic          o_wr_full;
  logic          i_rd_req, i_rd_hold, o_rd_rdy, i_rd_en;
  logic [AW-1:0] i_rd_addr;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_vld;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          o_mem_we;
  logic [DW-1:0] i_mem_rdata;
  logic [7:0]    o_blk_idx, o_drop_cnt;

  int tests = 0;
  int fails = 0;
  int we_cnt;

  logic [DW-1:0] mem [1 << AW];

  always #5 clk = ~clk;

  ice40_audio_buf_arb dut (
    .clk          (clk),
    .reset        (reset),
    .i_wr_req     (i_wr_req),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .i_wr_blk_end (i_wr_blk_end),
    .o_wr_full    (o_wr_full),
    .i_rd_req     (i_rd_req),
    .i_rd_hold    (i_rd_hold),
    .o_rd_rdy     (o_rd_rdy),
    .i_rd_en      (i_rd_en),
    .i_rd_addr    (i_rd_addr),
    .o_rd_data    (o_rd_data),
    .o_rd_vld     (o_rd_vld),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_we     (o_mem_we),
    .i_mem_rdata  (i_mem_rdata),
    .o_blk_idx    (o_blk_idx),
    .o_drop_cnt   (o_drop_cnt)
  );

  always @(posedge clk) begin
    if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
    i_mem_rdata <= mem[o_mem_addr];
    if (reset) we_cnt <= 0;
    else if (o_mem_we) we_cnt <= we_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic be);
    i_wr_req = 1'b1; i_wr_addr = a; i_wr_data = d; i_wr_blk_end = be;
  endtask

  initial begin
    int base;
    reset = 1'b1;
    i_wr_req = 0; i_wr_addr = '0; i_wr_data = '0; i_wr_blk_end = 0;
    i_rd_req = 0; i_rd_hold = 0; i_rd_en = 0; i_rd_addr = '0;
    cyc(2);
    reset = 1'b0;
    chk("rst_rdy", o_rd_rdy, 0);
    chk("rst_full", o_wr_full, 0);
    chk("rst_blk", o_blk_idx, 0);
    chk("rst_drop", o_drop_cnt, 0);
    chk("rst_we", o_mem_we, 0);
    chk("rst_vld", o_rd_vld, 0);

    // rd_en outside the lock window is ignored
    i_rd_en = 1; i_rd_addr = 14'h100;
    cyc();
    i_rd_en = 0;
    chk("rden_ignored", o_rd_vld, 0);

    // three writes, block end on the last
    wr(14'h10, 16'hA000, 0); cyc();
    chk("w0_we", o_mem_we, 1); chk("w0_addr", o_mem_addr, 14'h10);
    wr(14'h11, 16'hA001, 0); cyc();
    chk("w1_we", o_mem_we, 1); chk("w1_addr", o_mem_addr, 14'h11);
    wr(14'h12, 16'hA002, 1); cyc();
    chk("w2_we", o_mem_we, 1); chk("w2_addr", o_mem_addr, 14'h12);
    chk("w2_blk_pre", o_blk_idx, 0);
    wr(14'h100, 16'hBEEF, 0); cyc();
    chk("w2_blk_post", o_blk_idx, 1);
    chk("w3_addr", o_mem_addr, 14'h100);
    i_wr_req = 0; cyc();
    chk("idle_we", o_mem_we, 0);
    chk("we_cnt4", we_cnt, 4);
    chk("mem12", mem[14'h12], 16'hA002);

    // take the window with an empty queue
    i_rd_req = 1; cyc();
    chk("drain_rdy", o_rd_rdy, 0);
    cyc();
    chk("lock_rdy", o_rd_rdy, 1);
    i_rd_req = 0; i_rd_hold = 1;

    // read in lock
    i_rd_en = 1; i_rd_addr = 14'h100;
    chk("rd_addr", o_mem_addr, 14'h100);
    chk("rd_we", o_mem_we, 0);
    cyc();
    i_rd_en = 0;
    chk("rd_vld", o_rd_vld, 1);
    chk("rd_data", o_rd_data, 16'hBEEF);
    cyc();
    chk("rd_vld_off", o_rd_vld, 0);

    // 10 writes offered while locked: 8 queued, 2 dropped
    for (int i = 0; i < 10; i++) begin
      wr(AW'(32'h20 + i), DW'(32'hB000 + i), i == 7);
      cyc();
      chk("lock_no_we", o_mem_we, 0);
    end
    i_wr_req = 0;
    chk("lock_full", o_wr_full, 1);
    chk("lock_drop", o_drop_cnt, 2);
    cyc(8);
    chk("lock_rdy_held", o_rd_rdy, 1);
    chk("lock_we_cnt", we_cnt, 4);
    i_rd_hold = 0; cyc();
    chk("rel_rdy", o_rd_rdy, 0);
    chk("rel_we", o_mem_we, 1);
    chk("rel_addr", o_mem_addr, 14'h20);
    cyc(8);
    chk("rel_we_cnt", we_cnt, 12);
    chk("rel_full", o_wr_full, 0);
    chk("rel_blk", o_blk_idx, 2);
    chk("rel_we_off", o_mem_we, 0);
    chk("mem27", mem[14'h27], 16'hB007);

    // queue 5 entries under lock, then release with a rd_req pulse
    i_rd_req = 1; cyc(2);
    chk("lock2_rdy", o_rd_rdy, 1);
    i_rd_req = 0; i_rd_hold = 1;
    for (int i = 0; i < 5; i++) begin
      wr(AW'(32'h30 + i), DW'(32'hC000 + i), 0);
      cyc();
    end
    i_wr_req = 0;
    i_rd_hold = 0; cyc();
    i_rd_req = 1;
    chk("p0_we", o_mem_we, 1); chk("p0_addr", o_mem_addr, 14'h30);
    cyc();
    i_rd_req = 0;
    for (int i = 1; i < 5; i++) begin
      chk("drain_we", o_mem_we, 1);
      chk("drain_addr", o_mem_addr, AW'(32'h30 + i));
      chk("drain_nordy", o_rd_rdy, 0);
      cyc();
    end
    chk("drain_empty_rdy", o_rd_rdy, 0);
    chk("drain_empty_we", o_mem_we, 0);
    i_rd_hold = 1;
    cyc();
    chk("grant_rdy", o_rd_rdy, 1);
    chk("grant_we_cnt", we_cnt, 17);

    // reset mid-lock with 4 queued entries
    for (int i = 0; i < 4; i++) begin
      wr(AW'(32'h40 + i), 16'hD000, 1);
      cyc();
    end
    i_wr_req = 0;
    chk("pre_rst_drop", o_drop_cnt, 2);
    reset = 1; cyc();
    reset = 0; i_rd_hold = 0;
    chk("mrst_rdy", o_rd_rdy, 0);
    chk("mrst_blk", o_blk_idx, 0);
    chk("mrst_drop", o_drop_cnt, 0);
    chk("mrst_full", o_wr_full, 0);
    chk("mrst_we", o_mem_we, 0);
    cyc();
    chk("mrst_empty_we", o_mem_we, 0);
    chk("mrst_no_commit", we_cnt, 0);

    // blk_idx wraps 255 -> 0
    base = 0;
    for (int i = 0; i < 255; i++) begin
      wr(AW'(32'h200 + i), DW'(i), 1);
      cyc();
    end
    i_wr_req = 0; cyc(2);
    chk("blk_255", o_blk_idx, 8'd255);
    wr(14'h3FF, 16'h1234, 1); cyc();
    i_wr_req = 0; cyc(2);
    chk("blk_wrap", o_blk_idx, 8'd0);
    chk("wrap_we_cnt", we_cnt, 256 + base);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
